// File: rtl/gpa_fhdo_spi_responder_pkg.sv
// Shared types and constants for the GPA-FHDO SPI responder.
//   state_t       responder FSM states
//   GPA_ADDR_*    register addresses decoded from DAC write frames
//   GPA_*_BITS    default SPI frame lengths in SCLK rising edges
//   SYNC_RESET    reset value of the SYNC register
package gpa_fhdo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DAC_SHIFT,
      ST_ADC_SHIFT,
      ST_DECODE,
      ST_ERROR
   } state_t;

   localparam logic [3:0] GPA_ADDR_SYNC = 4'h2;
   localparam logic [3:0] GPA_ADDR_DAC0 = 4'h8;
   localparam logic [3:0] GPA_ADDR_DAC1 = 4'h9;
   localparam logic [3:0] GPA_ADDR_DAC2 = 4'hA;
   localparam logic [3:0] GPA_ADDR_DAC3 = 4'hB;

   localparam int GPA_DAC_BITS = 24;
   localparam int GPA_ADC_BITS = 32;

   localparam logic [15:0] SYNC_RESET = 16'hFF00;

   // True for the four DAC channel data registers.
   function automatic logic is_dac_addr(input logic [3:0] addr);
      return (addr >= GPA_ADDR_DAC0) && (addr <= GPA_ADDR_DAC3);
   endfunction

endpackage

// File: rtl/gpa_fhdo_spi_responder_if.sv
// SPI pin bundle between the gradient SPI master and the GPA-FHDO responder.
//   spi_clk_i  SCLK, idles low
//   spi_sdi_i  MOSI
//   dac_csn_i  DAC chip select, active-low
//   adc_csn_i  ADC chip select, active-low
//   spi_sdo_o  MISO
// Signal suffixes are from the responder's point of view.
interface gpa_fhdo_spi_responder_if;

   logic spi_clk_i;
   logic spi_sdi_i;
   logic dac_csn_i;
   logic adc_csn_i;
   logic spi_sdo_o;

   modport master (
      output spi_clk_i, spi_sdi_i, dac_csn_i, adc_csn_i,
      input  spi_sdo_o
   );

   modport slave (
      input  spi_clk_i, spi_sdi_i, dac_csn_i, adc_csn_i,
      output spi_sdo_o
   );

endinterface

// File: rtl/gpa_fhdo_spi_responder_spi_in_sync.sv
// N-stage single-bit synchroniser with a synchronous reset to RST_VAL.
//   clk   system clock
//   rst   synchronous active-high reset
//   d_i   asynchronous input
//   q_o   synchronised output (STAGES clocks of latency)
module spi_in_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gpa_fhdo_spi_responder.sv
// GPA-FHDO board emulator on the far side of the gradient SPI master.
// Oversamples the SPI pins on clk, decodes 24-bit DAC80504 write frames into
// four channel registers plus the SYNC register, and answers 32-bit ADC frames
// with a 16-bit sample (16 leading zeros, then the sample MSB-first).
//   clk, rst            system clock (>= 8x SCLK), sync active-high reset
//   spi                 SPI pins (slave modport)
//   adc_value_i         sample returned on the next ADC frame, latched at CSn fall
//   dac_ch0_o..3_o      current DAC channel codes
//   dac_wr_o/_ch_o      1-cycle pulse and channel of a channel register update
//   sync_reg_o          last value written to the SYNC register
//   frame_err_o         1-cycle pulse when a malformed frame is discarded
//   busy_o              a frame is in progress
module gpa_fhdo_spi_responder
   import gpa_fhdo_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DAC_BITS    = GPA_DAC_BITS,
   parameter int ADC_BITS    = GPA_ADC_BITS
) (
   input  logic                     clk,
   input  logic                     rst,
   gpa_fhdo_spi_responder_if.slave  spi,
   input  logic [15:0]              adc_value_i,
   output logic [15:0]              dac_ch0_o,
   output logic [15:0]              dac_ch1_o,
   output logic [15:0]              dac_ch2_o,
   output logic [15:0]              dac_ch3_o,
   output logic                     dac_wr_o,
   output logic [1:0]               dac_wr_ch_o,
   output logic [15:0]              sync_reg_o,
   output logic                     frame_err_o,
   output logic                     busy_o
);

   localparam logic [5:0] DAC_LAST = 6'(DAC_BITS);
   localparam logic [5:0] ADC_LAST = 6'(ADC_BITS);
   localparam logic [5:0] ADC_ZERO = 6'(ADC_BITS - 16);

   function automatic logic [5:0] sat_inc(input logic [5:0] cnt);
      return (cnt == 6'd63) ? cnt : cnt + 6'd1;
   endfunction

   // MISO bit the master samples on SCLK rise k.
   function automatic logic adc_bit(input logic [5:0] k, input logic [15:0] word);
      logic [5:0] idx;
      idx = ADC_LAST - 6'd1 - k;
      if ((k >= ADC_ZERO) && (k < ADC_LAST)) return word[idx[3:0]];
      return 1'b0;
   endfunction

   logic sclk_s, mosi_s, dcs_s, acs_s;

   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d_i(spi.spi_clk_i), .q_o(sclk_s));
   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .d_i(spi.spi_sdi_i), .q_o(mosi_s));
   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dcs (
      .clk(clk), .rst(rst), .d_i(spi.dac_csn_i), .q_o(dcs_s));
   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_acs (
      .clk(clk), .rst(rst), .d_i(spi.adc_csn_i), .q_o(acs_s));

   logic                   sclk_q, dcs_q, acs_q;
   logic [SYNC_STAGES-1:0] settle_q;
   logic                   armed_q;
   state_t                 state_q, state_d;
   logic [5:0]             bit_cnt_q, fall_cnt_q;
   logic [23:0]            shift_q;
   logic [15:0]            adc_q;
   logic                   sdo_q;
   logic [15:0]            dac_ch_q [4];
   logic [15:0]            sync_q;
   logic                   dac_wr_q, frame_err_q;
   logic [1:0]             dac_wr_ch_q;
   logic                   spi_sdo_w;

   wire sclk_rise = sclk_s & ~sclk_q;
   wire sclk_fall = ~sclk_s & sclk_q;
   wire dcs_fall  = ~dcs_s & dcs_q;
   wire dcs_rise  = dcs_s & ~dcs_q;
   wire acs_fall  = ~acs_s & acs_q;
   wire acs_rise  = acs_s & ~acs_q;
   wire settled   = settle_q[SYNC_STAGES-1];
   wire shifting  = (state_q == state_d) &&
                    ((state_q == ST_DAC_SHIFT) || (state_q == ST_ADC_SHIFT));

   logic unused_addr_hi;
   assign unused_addr_hi = ^shift_q[22:20];

   // Edge history. The synchronisers hold their reset levels for SYNC_STAGES
   // clocks after rst drops, so a CSn already low at release would look like a
   // fall; armed_q only sets once both CSn are seen truly high, which keeps an
   // aborted frame from being picked up mid-way.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_q   <= 1'b0;
         dcs_q    <= 1'b1;
         acs_q    <= 1'b1;
         settle_q <= '0;
         armed_q  <= 1'b0;
      end else begin
         sclk_q   <= sclk_s;
         dcs_q    <= dcs_s;
         acs_q    <= acs_s;
         settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
         armed_q  <= armed_q | (settled & dcs_s & acs_s);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // A CSn rise is checked before SCLK edges, so an edge in the same cycle is dropped.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (armed_q && (dcs_fall || acs_fall)) begin
               if (!dcs_s && !acs_s) state_d = ST_ERROR;
               else if (dcs_fall)    state_d = ST_DAC_SHIFT;
               else                  state_d = ST_ADC_SHIFT;
            end
         end
         ST_DAC_SHIFT: begin
            if (dcs_rise)
               state_d = ((bit_cnt_q == DAC_LAST) && (fall_cnt_q == DAC_LAST)) ? ST_DECODE : ST_ERROR;
            else if (acs_fall)
               state_d = ST_ERROR;
         end
         ST_ADC_SHIFT: begin
            if (acs_rise)
               state_d = (bit_cnt_q == ADC_LAST) ? ST_IDLE : ST_ERROR;
            else if (dcs_fall)
               state_d = ST_ERROR;
         end
         ST_DECODE: state_d = ST_IDLE;
         ST_ERROR:  if (dcs_s && acs_s) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o    = (state_q != ST_IDLE);
      spi_sdo_w = (state_q == ST_ADC_SHIFT) && sdo_q;
   end

   assign spi.spi_sdo_o = spi_sdo_w;

   always_ff @(posedge clk) begin
      if ((state_q == ST_IDLE) && (state_d == ST_DAC_SHIFT))
         shift_q <= '0;
      else if (shifting && (state_q == ST_DAC_SHIFT) && sclk_fall)
         shift_q <= {shift_q[22:0], mosi_s};
      if ((state_q == ST_IDLE) && (state_d == ST_ADC_SHIFT))
         adc_q <= adc_value_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q   <= '0;
         fall_cnt_q  <= '0;
         sdo_q       <= 1'b0;
         for (int i = 0; i < 4; i++) dac_ch_q[i] <= '0;
         sync_q      <= SYNC_RESET;
         dac_wr_q    <= 1'b0;
         dac_wr_ch_q <= '0;
         frame_err_q <= 1'b0;
      end else begin
         dac_wr_q    <= 1'b0;
         frame_err_q <= (state_d == ST_ERROR) && (state_q != ST_ERROR);
         if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
            bit_cnt_q  <= '0;
            fall_cnt_q <= '0;
            sdo_q      <= (state_d == ST_ADC_SHIFT) ? adc_bit(6'd0, adc_value_i) : 1'b0;
         end else if (shifting) begin
            if (sclk_rise) bit_cnt_q <= sat_inc(bit_cnt_q);
            if (sclk_fall) begin
               fall_cnt_q <= sat_inc(fall_cnt_q);
               if (state_q == ST_ADC_SHIFT) sdo_q <= adc_bit(bit_cnt_q, adc_q);
            end
         end else begin
            sdo_q <= 1'b0;
         end
         // Reads (bit 23 set) and unknown addresses are silently ignored.
         if ((state_q == ST_DECODE) && !shift_q[23]) begin
            if (is_dac_addr(shift_q[19:16])) begin
               dac_ch_q[shift_q[17:16]] <= shift_q[15:0];
               dac_wr_q                 <= 1'b1;
               dac_wr_ch_q              <= shift_q[17:16];
            end else if (shift_q[19:16] == GPA_ADDR_SYNC) begin
               sync_q <= shift_q[15:0];
            end
         end
      end
   end

   assign dac_ch0_o   = dac_ch_q[0];
   assign dac_ch1_o   = dac_ch_q[1];
   assign dac_ch2_o   = dac_ch_q[2];
   assign dac_ch3_o   = dac_ch_q[3];
   assign dac_wr_o    = dac_wr_q;
   assign dac_wr_ch_o = dac_wr_ch_q;
   assign sync_reg_o  = sync_q;
   assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_gpa_fhdo_spi_responder.sv
// Bench for gpa_fhdo_spi_responder: an SPI master model at clk/16 drives DAC
// and ADC frames; expected channel writes and ADC words go into queues and are
// checked when the responder produces them.
module tb_gpa_fhdo_spi_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] adc_value_i;
   logic [15:0] dac_ch0_o, dac_ch1_o, dac_ch2_o, dac_ch3_o;
   logic        dac_wr_o;
   logic [1:0]  dac_wr_ch_o;
   logic [15:0] sync_reg_o;
   logic        frame_err_o;
   logic        busy_o;

   always #5 clk = ~clk;

   gpa_fhdo_spi_responder_if spi_if ();

   gpa_fhdo_spi_responder dut (
      .clk         (clk),
      .rst         (rst),
      .spi         (spi_if.slave),
      .adc_value_i (adc_value_i),
      .dac_ch0_o   (dac_ch0_o),
      .dac_ch1_o   (dac_ch1_o),
      .dac_ch2_o   (dac_ch2_o),
      .dac_ch3_o   (dac_ch3_o),
      .dac_wr_o    (dac_wr_o),
      .dac_wr_ch_o (dac_wr_ch_o),
      .sync_reg_o  (sync_reg_o),
      .frame_err_o (frame_err_o),
      .busy_o      (busy_o)
   );

   typedef struct {
      logic [1:0]  ch;
      logic [15:0] val;
   } wr_exp_t;

   wr_exp_t     wr_q [$];
   logic [31:0] adc_exp_q [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          wr_pulses = 0;
   int          err_pulses = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ch_val(input logic [1:0] c);
      case (c)
         2'd0:    return dac_ch0_o;
         2'd1:    return dac_ch1_o;
         2'd2:    return dac_ch2_o;
         default: return dac_ch3_o;
      endcase
   endfunction

   // Write monitor: every dac_wr_o pulse must match the next queued write.
   always @(negedge clk) begin
      if (!rst) begin
         if (dac_wr_o) begin
            wr_exp_t e;
            wr_pulses++;
            if (wr_q.size() == 0) begin
               chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
               e = wr_q.pop_front();
               chk("wr_ch", 32'(dac_wr_ch_o), 32'(e.ch));
               chk("wr_val", 32'(ch_val(e.ch)), 32'(e.val));
            end
         end
         if (frame_err_o) err_pulses++;
      end
   end

   task automatic dac_frame(input logic [23:0] w, input int nbits, input int rst_at, input bit exp_wr);
      logic sdo_seen = 1'b0;
      int   lat = 0;
      @(negedge clk);
      spi_if.dac_csn_i = 1'b0;
      repeat (8) begin @(negedge clk); sdo_seen |= spi_if.spi_sdo_o; end
      for (int i = 0; i < nbits; i++) begin
         spi_if.spi_clk_i = 1'b1;
         spi_if.spi_sdi_i = w[23-i];
         if (i == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            chk("rst_busy", 32'(busy_o), 32'd0);
            rst = 1'b0;
            repeat (7) @(negedge clk);
         end else begin
            repeat (8) begin @(negedge clk); sdo_seen |= spi_if.spi_sdo_o; end
         end
         spi_if.spi_clk_i = 1'b0;
         repeat (8) begin @(negedge clk); sdo_seen |= spi_if.spi_sdo_o; end
      end
      spi_if.dac_csn_i = 1'b1;
      if (exp_wr) begin
         for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (dac_wr_o) lat = c;
         end
         chk("wr_latency", 32'(lat), 32'd4);
      end
      repeat (8) @(negedge clk);
      chk("dac_sdo_quiet", 32'(sdo_seen), 32'd0);
      chk("dac_busy_end", 32'(busy_o), 32'd0);
   endtask

   task automatic adc_frame(input logic [15:0] sample);
      logic [31:0] got = '0;
      logic [31:0] exp;
      adc_value_i = sample;
      adc_exp_q.push_back({16'h0000, sample});
      @(negedge clk);
      spi_if.adc_csn_i = 1'b0;
      repeat (4) @(negedge clk);
      adc_value_i = 16'h0000;
      chk("adc_busy", 32'(busy_o), 32'd1);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         got = {got[30:0], spi_if.spi_sdo_o};
         spi_if.spi_clk_i = 1'b1;
         repeat (8) @(negedge clk);
         spi_if.spi_clk_i = 1'b0;
         repeat (8) @(negedge clk);
      end
      spi_if.adc_csn_i = 1'b1;
      repeat (8) @(negedge clk);
      chk("adc_busy_end", 32'(busy_o), 32'd0);
      exp = adc_exp_q.pop_front();
      chk("adc_word", got, exp);
   endtask

   initial begin
      logic sdo_seen;
      rst              = 1'b1;
      adc_value_i      = 16'h0000;
      spi_if.spi_clk_i = 1'b0;
      spi_if.spi_sdi_i = 1'b0;
      spi_if.dac_csn_i = 1'b1;
      spi_if.adc_csn_i = 1'b1;
      repeat (4) @(negedge clk);

      chk("rst_sdo", 32'(spi_if.spi_sdo_o), 32'd0);
      chk("rst_ch0", 32'(dac_ch0_o), 32'd0);
      chk("rst_ch1", 32'(dac_ch1_o), 32'd0);
      chk("rst_ch2", 32'(dac_ch2_o), 32'd0);
      chk("rst_ch3", 32'(dac_ch3_o), 32'd0);
      chk("rst_sync", 32'(sync_reg_o), 32'h0000FF00);
      chk("rst_wr", 32'(dac_wr_o), 32'd0);
      chk("rst_wr_ch", 32'(dac_wr_ch_o), 32'd0);
      chk("rst_err", 32'(frame_err_o), 32'd0);
      chk("rst_busy0", 32'(busy_o), 32'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // DAC write to channel 2
      wr_q.push_back('{ch: 2'd2, val: 16'h1234});
      dac_frame(24'h0A1234, 24, -1, 1'b1);
      chk("t1_ch2", 32'(dac_ch2_o), 32'h1234);
      chk("t1_ch0", 32'(dac_ch0_o), 32'd0);
      chk("t1_ch1", 32'(dac_ch1_o), 32'd0);
      chk("t1_ch3", 32'(dac_ch3_o), 32'd0);
      chk("t1_wr_ch", 32'(dac_wr_ch_o), 32'd2);
      chk("t1_pulses", 32'(wr_pulses), 32'd1);

      // SYNC register write, then a read frame
      dac_frame(24'h020000, 24, -1, 1'b0);
      chk("t2_sync", 32'(sync_reg_o), 32'h0000);
      chk("t2_pulses", 32'(wr_pulses), 32'd1);
      dac_frame(24'h880000, 24, -1, 1'b0);
      chk("t2_rd_sync", 32'(sync_reg_o), 32'h0000);
      chk("t2_rd_ch0", 32'(dac_ch0_o), 32'd0);
      chk("t2_rd_ch2", 32'(dac_ch2_o), 32'h1234);
      chk("t2_rd_pulses", 32'(wr_pulses), 32'd1);
      chk("t2_err", 32'(err_pulses), 32'd0);

      // ADC frame
      adc_frame(16'hBEEF);
      chk("t3_err", 32'(err_pulses), 32'd0);

      // Truncated DAC frame, then a good one
      dac_frame(24'h0B5555, 20, -1, 1'b0);
      chk("t4_err", 32'(err_pulses), 32'd1);
      chk("t4_ch3", 32'(dac_ch3_o), 32'd0);
      chk("t4_ch2", 32'(dac_ch2_o), 32'h1234);
      chk("t4_pulses", 32'(wr_pulses), 32'd1);
      wr_q.push_back('{ch: 2'd3, val: 16'h00AA});
      dac_frame(24'h0B00AA, 24, -1, 1'b1);
      chk("t4_ch3_ok", 32'(dac_ch3_o), 32'h00AA);
      chk("t4_err_ok", 32'(err_pulses), 32'd1);

      // Both chip selects low together
      sdo_seen = 1'b0;
      @(negedge clk);
      spi_if.dac_csn_i = 1'b0;
      spi_if.adc_csn_i = 1'b0;
      repeat (16) begin @(negedge clk); sdo_seen |= spi_if.spi_sdo_o; end
      spi_if.dac_csn_i = 1'b1;
      spi_if.adc_csn_i = 1'b1;
      repeat (8) begin @(negedge clk); sdo_seen |= spi_if.spi_sdo_o; end
      chk("t5_err", 32'(err_pulses), 32'd2);
      chk("t5_sdo", 32'(sdo_seen), 32'd0);
      chk("t5_busy", 32'(busy_o), 32'd0);
      wr_q.push_back('{ch: 2'd0, val: 16'h0001});
      dac_frame(24'h080001, 24, -1, 1'b1);
      chk("t5_ch0", 32'(dac_ch0_o), 32'h0001);

      // Reset at SCLK edge 12 of a channel 1 write
      dac_frame(24'h091111, 24, 12, 1'b0);
      chk("t6_ch1", 32'(dac_ch1_o), 32'd0);
      chk("t6_ch2", 32'(dac_ch2_o), 32'd0);
      chk("t6_sync", 32'(sync_reg_o), 32'h0000FF00);
      chk("t6_err", 32'(err_pulses), 32'd2);
      chk("t6_pulses", 32'(wr_pulses), 32'd3);
      wr_q.push_back('{ch: 2'd2, val: 16'h0042});
      dac_frame(24'h0A0042, 24, -1, 1'b1);
      chk("t6_ch2_ok", 32'(dac_ch2_o), 32'h0042);
      chk("t6_pulses_ok", 32'(wr_pulses), 32'd4);

      chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
      chk("adc_q_drained", 32'(adc_exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
